// File: rtl/multicycle_cpu_if.sv
// multicycle_cpu_if: program and data memory request/acknowledge bundle
interface multicycle_cpu_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 8
);
   logic             prog_req;
   logic [AW-1:0]    prog_addr;
   logic [WIDTH-1:0] prog_data;
   logic             prog_ack;
   logic             mem_req;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ack;
   modport master (
      output prog_req, prog_addr, mem_req, mem_we, mem_addr, mem_wdata,
      input  prog_data, prog_ack, mem_rdata, mem_ack
   );
   modport slave (
      input  prog_req, prog_addr, mem_req, mem_we, mem_addr, mem_wdata,
      output prog_data, prog_ack, mem_rdata, mem_ack
   );
endinterface

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: accumulator CPU core with handshaked program and data memories
module multicycle_cpu #(
   parameter int WIDTH = 8,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             reset,
   multicycle_cpu_if.master bus,
   output logic [WIDTH-1:0] qreg,
   output logic             halted
);
   typedef enum logic [2:0] {FETCH, EXEC, OPER, MEM, HALT} state_t;
   state_t           state;
   logic [AW-1:0]    pc;
   logic [7:0]       ir;
   logic             carry, prog_req, mem_req, mem_we;
   logic [WIDTH-1:0] rf [4];
   logic [1:0]       cls, r, src;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] alu;
   logic             alu_c, taken, unused;
   assign cls           = ir[7:6];
   assign r             = ir[5:4];
   assign src           = ir[1:0];
   assign unused        = ir[3];
   assign sum           = {1'b0, rf[0]} + {1'b0, rf[1]};
   assign diff          = {1'b0, rf[0]} - {1'b0, rf[1]};
   assign alu           = ir[2] ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
   assign alu_c         = ir[2] ? ~diff[WIDTH] : sum[WIDTH];
   assign bus.prog_req  = prog_req;
   assign bus.prog_addr = pc;
   assign bus.mem_req   = mem_req;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = rf[2][AW-1:0];
   assign bus.mem_wdata = rf[r];
   assign qreg          = rf[3];
   // jump condition on the live A and carry, used while the target word is read
   always_comb
      taken = src == 2'd0 ? 1'b1 :
              src == 2'd1 ? (rf[0] == '0) :
              src == 2'd2 ? carry : (rf[0] != '0);
   // control FSM; requests are registered so they only change with the state
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= FETCH;
         pc       <= '0;
         ir       <= '0;
         carry    <= 1'b0;
         prog_req <= 1'b0;
         mem_req  <= 1'b0;
         mem_we   <= 1'b0;
         halted   <= 1'b0;
         for (int i = 0; i < 4; i++) rf[i] <= '0;
      end else begin
         case (state)
            FETCH:
               if (!prog_req) prog_req <= 1'b1;
               else if (bus.prog_ack) begin
                  ir       <= bus.prog_data[7:0];
                  pc       <= pc + AW'(1);
                  prog_req <= 1'b0;
                  state    <= EXEC;
               end
            EXEC:
               if (cls == 2'b11) begin
                  halted   <= ir[0];
                  prog_req <= !ir[0];
                  state    <= ir[0] ? HALT : FETCH;
               end else if (cls == 2'b01 || (cls == 2'b00 && src == 2'd1)) begin
                  mem_req <= 1'b1;
                  mem_we  <= cls[0];
                  state   <= MEM;
               end else if (cls == 2'b10 || src == 2'd0) begin
                  prog_req <= 1'b1;
                  state    <= OPER;
               end else begin
                  rf[r]    <= src == 2'd2 ? alu : rf[0];
                  carry    <= src == 2'd2 ? alu_c : carry;
                  prog_req <= 1'b1;
                  state    <= FETCH;
               end
            OPER:
               if (bus.prog_ack) begin
                  if (cls[1]) pc <= taken ? bus.prog_data[AW-1:0] : pc + AW'(1);
                  else begin
                     rf[r] <= bus.prog_data;
                     pc    <= pc + AW'(1);
                  end
                  state <= FETCH;
               end
            MEM:
               if (bus.mem_ack) begin
                  if (!mem_we) rf[r] <= bus.mem_rdata;
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  prog_req <= 1'b1;
                  state    <= FETCH;
               end
            HALT: ;
            default: state <= HALT;
         endcase
      end
endmodule
